// File: rtl/ahb_arb_pkg.sv
// ahb_arb_pkg: shared types and helpers for the two-master AHB-Lite arbiter
package ahb_arb_pkg;
   localparam int NMASTERS = 2;
   typedef enum logic {OWN0 = 1'b0, OWN1 = 1'b1} owner_t;
   function automatic int hold_w(input int max_hold);
      return (max_hold > 1) ? $clog2(max_hold) : 1;
   endfunction
endpackage

// File: rtl/ahb_arb_rr.sv
// ahb_arb_rr: next-owner round-robin with optional locked hold (AHB_ARB_LOCK_EN)
module ahb_arb_rr
   import ahb_arb_pkg::*;
`ifdef AHB_ARB_LOCK_EN
#(
   parameter int MAX_HOLD = 4,
   parameter int HW = hold_w(MAX_HOLD)
)
`endif
(
   input  owner_t              owner,
   input  logic [NMASTERS-1:0] hreq,
`ifdef AHB_ARB_LOCK_EN
   input  logic [NMASTERS-1:0] hlock,
   input  logic [HW-1:0]       hold,
   output logic [HW-1:0]       nxt_hold,
`endif
   output owner_t              nxt_owner
);
`ifdef AHB_ARB_LOCK_EN
   logic stay_lock;
   always_comb begin
      stay_lock = hlock[owner] & hreq[owner] & (~hreq[~owner] | (hold < HW'(MAX_HOLD - 1)));
      nxt_owner = (!stay_lock && hreq[~owner]) ? owner_t'(~owner) : owner;
      nxt_hold  = !stay_lock ? '0 : (hold == HW'(MAX_HOLD - 1)) ? hold : hold + 1'b1;
   end
`else
   always_comb nxt_owner = hreq[~owner] ? owner_t'(~owner) : owner;
`endif
endmodule

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: two-master AHB-Lite arbiter with data-phase routing; HLOCK honoured
// only when AHB_ARB_LOCK_EN is defined.
module ahb_bus_arbiter
   import ahb_arb_pkg::*;
#(
   parameter int MAX_HOLD    = 4,
   parameter int RESET_OWNER = 0
) (
   input  logic                       HCLK,
   input  logic                       HRESETn,
   input  logic [NMASTERS-1:0]        HREQ,
   input  logic [NMASTERS-1:0]        HLOCK,
   input  logic [NMASTERS-1:0][31:0]  M_HADDR,
   input  logic [NMASTERS-1:0]        M_HWRITE,
   input  logic [NMASTERS-1:0][31:0]  M_HWDATA,
   output logic [NMASTERS-1:0]        HGRANT,
   output logic [NMASTERS-1:0]        HDONE,
   output logic [NMASTERS-1:0]        HRVALID,
   output logic [31:0]                M_HRDATA,
   output logic [31:0]                HADDR,
   output logic                       HWRITE,
   output logic [31:0]                HWDATA,
   input  logic [31:0]                HRDATA
);
   localparam owner_t RST_OWN = owner_t'(RESET_OWNER != 0);
   owner_t owner, nxt_owner, downer;
   logic   dvalid, dwrite;
`ifdef AHB_ARB_LOCK_EN
   localparam int HW = hold_w(MAX_HOLD);
   logic [HW-1:0] hold, nxt_hold;
   ahb_arb_rr #(.MAX_HOLD(MAX_HOLD)) u_rr (
      .owner(owner), .hreq(HREQ), .hlock(HLOCK), .hold(hold), .nxt_hold(nxt_hold), .nxt_owner(nxt_owner)
   );
   always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn) hold <= '0;
      else hold <= nxt_hold;
`else
   localparam int unused_max_hold = MAX_HOLD;
   logic unused_lock;
   assign unused_lock = ^HLOCK;
   ahb_arb_rr u_rr (.owner(owner), .hreq(HREQ), .nxt_owner(nxt_owner));
`endif
   // Reset drops any in-flight data phase so no HDONE or late write escapes
   always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn) begin
         owner  <= RST_OWN;
         dvalid <= 1'b0;
         downer <= OWN0;
         dwrite <= 1'b0;
      end else begin
         owner  <= nxt_owner;
         dvalid <= HREQ[owner];
         downer <= owner;
         dwrite <= HWRITE;
      end
   always_comb begin
      HGRANT   = {owner == OWN1, owner == OWN0};
      HADDR    = M_HADDR[owner];
      HWRITE   = M_HWRITE[owner] & HREQ[owner];
      HWDATA   = M_HWDATA[downer];
      M_HRDATA = HRDATA;
      HDONE    = {dvalid & (downer == OWN1), dvalid & (downer == OWN0)};
      HRVALID  = HDONE & {NMASTERS{~dwrite}};
   end
endmodule
